mc_ctrl_unit: RTL and testbench

//  Next-generation multicycle MIPS control unit: Moore FSM with main and ALU decode.

---
 rtl/mc_ctrl_pkg.sv | 85 ++++++++
 rtl/mc_alu_dec.sv | 48 ++++
 rtl/mc_ctrl_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle MIPS control unit.
// Holds the FSM state encoding, the opcode and funct constants, the aluop and
// alucontrol codes, and the mux-select encodings driven toward the datapath.
package mc_ctrl_pkg;

  // FSM states; TRAP is terminal and is left only through reset.
  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_RTYPEEX = 5'd6,
    S_RTYPEWB = 5'd7,
    S_BEQEX   = 5'd8,
    S_BNEEX   = 5'd9,
    S_IMMEX   = 5'd10,
    S_IMMWB   = 5'd11,
    S_JEX     = 5'd12,
    S_JALEX   = 5'd13,
    S_TRAP    = 5'd14
  } state_t;

  // ALU decode selector produced by the main FSM.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_t;

  // Opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0]).
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // alucontrol codes.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Datapath mux selects.
  localparam logic [1:0] REGDST_RT     = 2'b00;
  localparam logic [1:0] REGDST_RD     = 2'b01;
  localparam logic [1:0] REGDST_R31    = 2'b10;
  localparam logic [1:0] WDSRC_ALUOUT  = 2'b00;
  localparam logic [1:0] WDSRC_DATA    = 2'b01;
  localparam logic [1:0] WDSRC_PC      = 2'b10;
  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMMSH    = 2'b11;
  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;

  // Trap causes.
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that wait on mem_ready and therefore run the wait counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU decoder.
// Ports:
//   aluop         in  2  selector from the main FSM (add/sub/funct/imm)
//   op            in  6  opcode, used for immediate-class instructions
//   funct         in  6  R-type funct field
//   alucontrol    out 3  ALU operation code
//   funct_illegal out 1  funct not recognised (only meaningful for aluop=funct)
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  // Map aluop/op/funct onto the ALU operation.
  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      ALUOP_IMM: begin
        case (op)
          OP_ADDI: alucontrol = ALU_ADD;
          OP_ANDI: alucontrol = ALU_AND;
          OP_ORI:  alucontrol = ALU_OR;
          OP_SLTI: alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle MIPS control unit (Moore FSM + ALU decode).
// Sits between the instruction register and the multicycle datapath.
// Memory states (FETCH, MEMRD, MEMWR) wait on mem_ready; a wait counter traps
// the machine when WAIT_MAX consecutive not-ready cycles elapse (0 disables).
// Illegal opcode/funct and bus timeout enter a sticky TRAP left only by reset.
// Optional feature macro: MC_CTRL_PERF_EN adds saturating cycle/instruction
// counters; when undefined the counter ports read 0 and no flops exist.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   op, funct             instr[31:26], instr[5:0]
//   zero                  ALU zero flag (branch resolution)
//   mem_ready             memory completes the current access this cycle
//   memreq, memwrite      memory request / write strobe
//   pcen, irwrite, regwrite  PC, IR and register-file load enables
//   alusrca, iord, immext, regdst, wdsrc, alusrcb, pcsrc  datapath selects
//   alucontrol            ALU operation
//   trap, trap_cause      sticky trap flag and cause (01 illegal, 10 timeout)
//   cycle_cnt, instr_cnt  performance counters (MC_CTRL_PERF_EN only)
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned WAIT_W   = 5,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memreq,
  output logic             memwrite,
  output logic             pcen,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             immext,
  output logic [1:0]       regdst,
  output logic [1:0]       wdsrc,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // Counter value seen during the last not-ready cycle before a timeout.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 32'd1);
  localparam logic              TIMEOUT_EN = (WAIT_MAX != 32'd0);

  state_t            state_r;
  state_t            next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [1:0]        trap_cause_r;
  aluop_t            aluop_s;
  logic              funct_illegal_s;
  logic              mem_state_s;
  logic              timeout_s;

  logic memreq_s, memwrite_s, pcen_s, irwrite_s, regwrite_s;

  assign mem_state_s = is_mem_state(state_r);
  // Timeout fires on the not-ready cycle that would push the count to WAIT_MAX.
  assign timeout_s   = TIMEOUT_EN && mem_state_s && !mem_ready && (wait_cnt_r == WAIT_LAST);

  mc_alu_dec u_alu_dec (
    .aluop         (aluop_s),
    .op            (op),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal_s)
  );

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (timeout_s)      next_s = S_TRAP;
        else if (mem_ready) next_s = S_DECODE;
        else                next_s = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                     next_s = S_MEMADR;
          OP_RTYPE:                         next_s = S_RTYPEEX;
          OP_BEQ:                           next_s = S_BEQEX;
          OP_BNE:                           next_s = S_BNEEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_s = S_IMMEX;
          OP_J:                             next_s = S_JEX;
          OP_JAL:                           next_s = S_JALEX;
          default:                          next_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      next_s = S_MEMRD;
        else if (op == OP_SW) next_s = S_MEMWR;
        else                  next_s = S_TRAP;
      end
      S_MEMRD: begin
        if (timeout_s)      next_s = S_TRAP;
        else if (mem_ready) next_s = S_MEMWB;
        else                next_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (timeout_s)      next_s = S_TRAP;
        else if (mem_ready) next_s = S_FETCH;
        else                next_s = S_MEMWR;
      end
      S_MEMWB:   next_s = S_FETCH;
      S_RTYPEEX: begin
        if (funct_illegal_s) next_s = S_TRAP;
        else                 next_s = S_RTYPEWB;
      end
      S_RTYPEWB: next_s = S_FETCH;
      S_BEQEX:   next_s = S_FETCH;
      S_BNEEX:   next_s = S_FETCH;
      S_IMMEX:   next_s = S_IMMWB;
      S_IMMWB:   next_s = S_FETCH;
      S_JEX:     next_s = S_FETCH;
      S_JALEX:   next_s = S_FETCH;
      S_TRAP:    next_s = S_TRAP;
      default:   next_s = S_TRAP;
    endcase
  end

  // State register, wait counter and trap cause.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_FETCH;
      wait_cnt_r   <= {WAIT_W{1'b0}};
      trap_cause_r <= CAUSE_NONE;
    end else begin
      state_r <= next_s;
      // Non-memory states hold the counter at 0, so entry always starts clean.
      if (mem_state_s && !mem_ready) begin
        if (wait_cnt_r != {WAIT_W{1'b1}}) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        else                              wait_cnt_r <= wait_cnt_r;
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
      if ((next_s == S_TRAP) && (state_r != S_TRAP)) begin
        trap_cause_r <= timeout_s ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
      end else begin
        trap_cause_r <= trap_cause_r;
      end
    end
  end

  // Output decode from the current state; a few strobes are qualified by inputs.
  always_comb begin
    memreq_s   = 1'b0;
    memwrite_s = 1'b0;
    pcen_s     = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    immext     = 1'b0;
    regdst     = REGDST_RT;
    wdsrc      = WDSRC_ALUOUT;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALU;
    aluop_s    = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        memreq_s  = !timeout_s;
        pcen_s    = mem_ready;
        irwrite_s = mem_ready;
        alusrcb   = SRCB_FOUR;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memreq_s = !timeout_s;
        iord     = 1'b1;
      end
      S_MEMWR: begin
        memreq_s   = !timeout_s;
        memwrite_s = !timeout_s;
        iord       = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        regdst     = REGDST_RT;
        wdsrc      = WDSRC_DATA;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_B;
        aluop_s = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = REGDST_RD;
        wdsrc      = WDSRC_ALUOUT;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_B;
        aluop_s = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pcen_s  = (state_r == S_BEQEX) ? zero : !zero;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop_s = ALUOP_IMM;
        immext  = (op == OP_ANDI) || (op == OP_ORI);
      end
      S_IMMWB: begin
        regwrite_s = 1'b1;
        regdst     = REGDST_RT;
        wdsrc      = WDSRC_ALUOUT;
      end
      S_JEX: begin
        pcsrc  = PCSRC_JUMP;
        pcen_s = 1'b1;
      end
      S_JALEX: begin
        pcsrc      = PCSRC_JUMP;
        pcen_s     = 1'b1;
        regwrite_s = 1'b1;
        regdst     = REGDST_R31;
        wdsrc      = WDSRC_PC;
      end
      S_TRAP:  aluop_s = ALUOP_ADD;
      default: aluop_s = ALUOP_ADD;
    endcase
  end

  // Strobes drop immediately while reset is asserted, independent of state.
  assign memreq     = memreq_s   & reset_n;
  assign memwrite   = memwrite_s & reset_n;
  assign pcen       = pcen_s     & reset_n;
  assign irwrite    = irwrite_s  & reset_n;
  assign regwrite   = regwrite_s & reset_n;
  assign trap       = (state_r == S_TRAP);
  assign trap_cause = trap_cause_r;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] instr_cnt_r;

  // Saturating performance counters, frozen once the FSM has trapped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
      instr_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != S_TRAP) begin
      if (cycle_cnt_r != {CNT_W{1'b1}}) cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      else                              cycle_cnt_r <= cycle_cnt_r;
      if ((state_r == S_FETCH) && mem_ready && (instr_cnt_r != {CNT_W{1'b1}}))
        instr_cnt_r <= instr_cnt_r + CNT_W'(1);
      else
        instr_cnt_r <= instr_cnt_r;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign instr_cnt = instr_cnt_r;
`else
  assign cycle_cnt = {CNT_W{1'b0}};
  assign instr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: scoreboard bench for mc_ctrl_unit.
// The stimulus process walks instruction sequences cycle by cycle, deriving the
// expected strobes/selects of each cycle from the ISA-level rules and queueing
// them; a negedge monitor pops and compares against the DUT outputs.
module tb_mc_ctrl_unit;

  localparam int WMAX = 4;

  localparam logic [5:0] R_OP = 6'b000000, J_OP = 6'b000010, JAL_OP = 6'b000011;
  localparam logic [5:0] BEQ_OP = 6'b000100, BNE_OP = 6'b000101, ADDI_OP = 6'b001000;
  localparam logic [5:0] SLTI_OP = 6'b001010, ANDI_OP = 6'b001100, ORI_OP = 6'b001101;
  localparam logic [5:0] LW_OP = 6'b100011, SW_OP = 6'b101011;
  localparam logic [5:0] F_ADDF = 6'b100000, F_SUBF = 6'b100010, F_ANDF = 6'b100100;
  localparam logic [5:0] F_ORF = 6'b100101, F_SLTF = 6'b101010;

  // bit positions of each select inside the packed select vector
  localparam int F_ALU = 0, F_PCSRC = 3, F_SRCB = 5, F_WD = 7, F_RD = 9;
  localparam int F_IMX = 11, F_IORD = 12, F_SRCA = 13;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        memreq, memwrite, pcen, irwrite, regwrite;
  logic        alusrca, iord, immext;
  logic [1:0]  regdst, wdsrc, alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_cnt, instr_cnt;

  mc_ctrl_unit #(.WAIT_MAX(WMAX), .WAIT_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .memreq(memreq), .memwrite(memwrite), .pcen(pcen),
    .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
    .immext(immext), .regdst(regdst), .wdsrc(wdsrc), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // stb = {memreq, memwrite, pcen, irwrite, regwrite, trap}
  typedef struct {
    string       tag;
    logic [5:0]  stb;
    logic [1:0]  cause;
    logic [13:0] sel;
    logic [13:0] msk;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t blank(input string tag);
    exp_t e;
    e.tag = tag; e.stb = 6'd0; e.cause = 2'b00; e.sel = 14'd0; e.msk = 14'd0;
    return e;
  endfunction

  function automatic exp_t put(input exp_t e, input int lsb, input int w, input logic [2:0] v);
    for (int i = 0; i < w; i++) begin
      e.sel[lsb+i] = v[i];
      e.msk[lsb+i] = 1'b1;
    end
    return e;
  endfunction

  // ISA-level ALU operation for an instruction
  function automatic logic [2:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    if (o == R_OP) begin
      if (f == F_SUBF) return 3'b110;
      if (f == F_ANDF) return 3'b000;
      if (f == F_ORF)  return 3'b001;
      if (f == F_SLTF) return 3'b111;
      return 3'b010;
    end
    if (o == ANDI_OP) return 3'b000;
    if (o == ORI_OP)  return 3'b001;
    if (o == SLTI_OP) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t e_fetch(input logic r);
    exp_t e = blank(r ? "fetch_rdy" : "fetch_wait");
    e.stb = {1'b1, 1'b0, r, r, 1'b0, 1'b0};
    e = put(e, F_ALU, 3, 3'b010); e = put(e, F_PCSRC, 2, 3'b000);
    e = put(e, F_SRCB, 2, 3'b001); e = put(e, F_IORD, 1, 3'b000);
    e = put(e, F_SRCA, 1, 3'b000);
    return e;
  endfunction

  function automatic exp_t e_mem(input logic wr);
    exp_t e = blank(wr ? "memwr" : "memrd");
    e.stb = {1'b1, wr, 4'b0000};
    e = put(e, F_IORD, 1, 3'b001);
    return e;
  endfunction

  function automatic exp_t e_trap(input logic [1:0] c);
    exp_t e = blank("trap");
    e.stb = 6'b000001; e.cause = c;
    return e;
  endfunction

  // Monitor: compare every queued expectation against the DUT at negedge.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [5:0]  a_stb;
    logic [13:0] a_sel;
    if (q.size() > 0) begin
      e = q.pop_front();
      a_stb = {memreq, memwrite, pcen, irwrite, regwrite, trap};
      a_sel = {alusrca, iord, immext, regdst, wdsrc, alusrcb, pcsrc, alucontrol};
      n_tests++;
      if (a_stb !== e.stb || trap_cause !== e.cause || ((a_sel ^ e.sel) & e.msk) !== 14'd0) begin
        n_fail++;
        $display("FAIL %s: got stb=%b cause=%b sel=%b, want stb=%b cause=%b sel=%b (mask %b)",
                 e.tag, a_stb, trap_cause, a_sel, e.stb, e.cause, e.sel, e.msk);
      end
    end
  end

  task automatic cyc(input logic rdy, input exp_t e);
    mem_ready = rdy;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) cyc(1'b0, blank("reset"));
    reset_n = 1'b1;
  endtask

  task automatic trap_hold(input logic [1:0] c, input int n);
    repeat (n) cyc(rb(), e_trap(c));
  endtask

  task automatic front(input logic [5:0] o, input logic [5:0] f, input logic z, input int fw);
    exp_t e;
    op = o; funct = f; zero = z;
    for (int i = 0; i < fw; i++) cyc(1'b0, e_fetch(1'b0));
    cyc(1'b1, e_fetch(1'b1));
    e = blank("decode"); e = put(e, F_SRCB, 2, 3'b011); e = put(e, F_ALU, 3, 3'b010);
    cyc(rb(), e);
  endtask

  function automatic exp_t e_memadr();
    exp_t e = blank("memadr");
    e = put(e, F_SRCA, 1, 3'b001); e = put(e, F_SRCB, 2, 3'b010); e = put(e, F_ALU, 3, 3'b010);
    return e;
  endfunction

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int fw, input int mw);
    exp_t e;
    logic taken;
    front(o, f, z, fw);
    if (o == LW_OP || o == SW_OP) begin
      cyc(rb(), e_memadr());
      for (int i = 0; i < mw; i++) cyc(1'b0, e_mem(o == SW_OP));
      cyc(1'b1, e_mem(o == SW_OP));
      if (o == LW_OP) begin
        e = blank("memwb"); e.stb = 6'b000010;
        e = put(e, F_RD, 2, 3'b000); e = put(e, F_WD, 2, 3'b001);
        cyc(rb(), e);
      end
    end else if (o == R_OP) begin
      e = blank("rtypeex"); e = put(e, F_ALU, 3, alu_of(o, f));
      cyc(rb(), e);
      e = blank("rtypewb"); e.stb = 6'b000010;
      e = put(e, F_RD, 2, 3'b001); e = put(e, F_WD, 2, 3'b000);
      cyc(rb(), e);
    end else if (o == BEQ_OP || o == BNE_OP) begin
      taken = (o == BEQ_OP) ? z : !z;
      e = blank(o == BEQ_OP ? "beqex" : "bneex"); e.stb = {2'b00, taken, 3'b000};
      e = put(e, F_SRCA, 1, 3'b001); e = put(e, F_SRCB, 2, 3'b000);
      e = put(e, F_ALU, 3, 3'b110); e = put(e, F_PCSRC, 2, 3'b001);
      cyc(rb(), e);
    end else if (o == ADDI_OP || o == ANDI_OP || o == ORI_OP || o == SLTI_OP) begin
      e = blank("immex");
      e = put(e, F_SRCA, 1, 3'b001); e = put(e, F_SRCB, 2, 3'b010);
      e = put(e, F_IMX, 1, {2'b00, (o == ANDI_OP || o == ORI_OP)});
      e = put(e, F_ALU, 3, alu_of(o, f));
      cyc(rb(), e);
      e = blank("immwb"); e.stb = 6'b000010;
      e = put(e, F_RD, 2, 3'b000); e = put(e, F_WD, 2, 3'b000);
      cyc(rb(), e);
    end else if (o == J_OP || o == JAL_OP) begin
      e = blank(o == J_OP ? "jex" : "jalex");
      e.stb = {2'b00, 1'b1, 2'b00, 1'b0};
      e = put(e, F_PCSRC, 2, 3'b010);
      if (o == JAL_OP) begin
        e.stb[1] = 1'b1;
        e = put(e, F_RD, 2, 3'b010); e = put(e, F_WD, 2, 3'b010);
      end
      cyc(rb(), e);
    end
  endtask

  logic [5:0] legal_op [15];
  logic [5:0] legal_fn [15];

  initial begin
    legal_op = '{R_OP, R_OP, R_OP, R_OP, R_OP, LW_OP, SW_OP, BEQ_OP, BNE_OP,
                 ADDI_OP, ANDI_OP, ORI_OP, SLTI_OP, J_OP, JAL_OP};
    legal_fn = '{F_ADDF, F_SUBF, F_ANDF, F_ORF, F_SLTF, 6'h00, 6'h00, 6'h00, 6'h00,
                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    reset_n = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // reset, then three back-to-back adds with no wait states
    do_reset(2);
    repeat (3) do_instr(R_OP, F_ADDF, rb(), 0, 0);
    n_tests++;
`ifdef MC_CTRL_PERF_EN
    if (cycle_cnt !== 32'd12 || instr_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_cnt: got cycle=%0d instr=%0d, want cycle=12 instr=3", cycle_cnt, instr_cnt);
    end
`else
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_cnt: got cycle=%0d instr=%0d, want 0 and 0", cycle_cnt, instr_cnt);
    end
`endif

    // directed instruction mix
    do_instr(LW_OP, 6'h00, 1'b0, 0, 3);
    do_instr(SW_OP, 6'h00, 1'b0, 1, 2);
    do_instr(BNE_OP, 6'h00, 1'b0, 0, 0);
    do_instr(BNE_OP, 6'h00, 1'b1, 0, 0);
    do_instr(BEQ_OP, 6'h00, 1'b0, 0, 0);
    do_instr(BEQ_OP, 6'h00, 1'b1, 0, 0);
    do_instr(JAL_OP, 6'h00, 1'b0, 0, 0);
    do_instr(ANDI_OP, 6'h00, 1'b0, 2, 0);
    do_instr(ORI_OP, 6'h00, 1'b1, 0, 0);
    do_instr(SLTI_OP, 6'h00, 1'b0, 0, 0);
    do_instr(J_OP, 6'h00, 1'b0, 3, 0);

    // randomized legal instructions, wait states kept below the timeout
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 14));
      do_instr(legal_op[k], legal_fn[k], rb(), int'($urandom_range(0, WMAX-1)),
               int'($urandom_range(0, WMAX-1)));
    end

    // reset asserted while lw waits in MEMRD, then a clean fetch pulse
    front(LW_OP, 6'h00, 1'b0, 0);
    cyc(rb(), e_memadr());
    cyc(1'b0, e_mem(1'b0));
    cyc(1'b0, e_mem(1'b0));
    do_reset(2);
    do_instr(R_OP, F_ORF, 1'b0, 0, 0);

    // bus timeout in FETCH
    for (int i = 1; i < WMAX; i++) cyc(1'b0, e_fetch(1'b0));
    cyc(1'b0, blank("fetch_timeout"));
    trap_hold(2'b10, 3);
    do_reset(2);

    // bus timeout in MEMWR
    front(SW_OP, 6'h00, 1'b0, 0);
    cyc(rb(), e_memadr());
    for (int i = 1; i < WMAX; i++) cyc(1'b0, e_mem(1'b1));
    cyc(1'b0, blank("memwr_timeout"));
    trap_hold(2'b10, 3);
    do_reset(2);

    // illegal opcode
    front(6'h3F, 6'h00, 1'b0, 0);
    trap_hold(2'b01, 4);
    do_reset(1);

    // illegal funct: one RTYPEEX cycle, no register write, then trap
    front(R_OP, 6'h3F, 1'b0, 0);
    cyc(rb(), blank("rtypeex_bad"));
    trap_hold(2'b01, 3);
    do_reset(1);
    do_instr(ADDI_OP, 6'h00, 1'b0, 0, 0);

    @(negedge clk); #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
